// File: rtl/lp_filter.sv
// lp_filter: cascaded first-order EMA low-pass for unsigned samples, STAGE_COUNT stages of coefficient 2^-SHIFT_BITS.
// Define LP_FILTER_ROUND_EN to round the stage outputs instead of truncating them.
module lp_filter #(
  parameter int DATA_BITS   = 28,
  parameter int SHIFT_BITS  = 4,
  parameter int STAGE_COUNT = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 CE,
  input  logic [DATA_BITS-1:0] IN_VALUE,
  output logic [DATA_BITS-1:0] OUT_VALUE
);
  localparam int AW = DATA_BITS + SHIFT_BITS + 1;
`ifdef LP_FILTER_ROUND_EN
  localparam logic [AW-1:0] HALF = AW'(2 ** SHIFT_BITS) >> 1;
`else
  localparam logic [AW-1:0] HALF = '0;
`endif
  logic [DATA_BITS-1:0] in_q;
  always_ff @(posedge CLK) in_q <= RESET ? '0 : CE ? IN_VALUE : in_q;
  if (STAGE_COUNT == 0) begin : g_bypass
    assign OUT_VALUE = in_q;
  end else begin : g_stages
    logic [DATA_BITS-1:0] y [STAGE_COUNT];
    for (genvar s = 0; s < STAGE_COUNT; s++) begin : g_s
      logic [AW-1:0] acc_q, acc_d;
      logic [DATA_BITS-1:0] x;
      if (s == 0) begin : g_first
        assign x = in_q;
      end else begin : g_next
        assign x = y[s-1];
      end
      // the shifted accumulator always fits DATA_BITS, so y doubles as the leak term
      assign y[s]  = DATA_BITS'((acc_q + HALF) >> SHIFT_BITS);
      assign acc_d = acc_q + AW'(x) - AW'(y[s]);
      always_ff @(posedge CLK) acc_q <= RESET ? '0 : CE ? acc_d : acc_q;
    end
    assign OUT_VALUE = y[STAGE_COUNT-1];
  end
endmodule

// File: tb/tb_lp_filter.sv
// tb_lp_filter: directed checks of lp_filter with STAGE_COUNT 0..4 side by side (DATA_BITS=28, S=4).
module tb_lp_filter;
  localparam int D = 28;
  localparam logic [D-1:0] X  = 28'd109377165;
  localparam logic [D-1:0] XL = 28'd54688582;
  localparam logic [D-1:0] XH = 28'd109377164;
  localparam logic [D-1:0] XM = 28'd268435455;
`ifdef LP_FILTER_ROUND_EN
  localparam logic [D-1:0] FIRST1  = 28'd6836073;
  localparam logic [D-1:0] SECOND2 = 28'd427255;
`else
  localparam logic [D-1:0] FIRST1  = 28'd6836072;
  localparam logic [D-1:0] SECOND2 = 28'd427254;
`endif
  logic clk = 1'b0, rst = 1'b1, ce = 1'b1;
  logic [D-1:0] in_v = '0;
  logic [D-1:0] out [5];
  logic [D-1:0] prev [5];
  logic [D-1:0] held [5];
  logic mono [5];
  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  lp_filter #(.STAGE_COUNT(0)) u0 (.CLK(clk), .RESET(rst), .CE(ce), .IN_VALUE(in_v), .OUT_VALUE(out[0]));
  lp_filter #(.STAGE_COUNT(1)) u1 (.CLK(clk), .RESET(rst), .CE(ce), .IN_VALUE(in_v), .OUT_VALUE(out[1]));
  lp_filter #(.STAGE_COUNT(2)) u2 (.CLK(clk), .RESET(rst), .CE(ce), .IN_VALUE(in_v), .OUT_VALUE(out[2]));
  lp_filter #(.STAGE_COUNT(3)) u3 (.CLK(clk), .RESET(rst), .CE(ce), .IN_VALUE(in_v), .OUT_VALUE(out[3]));
  lp_filter #(.STAGE_COUNT(4)) u4 (.CLK(clk), .RESET(rst), .CE(ce), .IN_VALUE(in_v), .OUT_VALUE(out[4]));

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [D-1:0] obs, input logic [D-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [D-1:0] exp);
    for (int i = 0; i < 5; i++) chk($sformatf("%s_n%0d", tag, i), out[i], exp);
  endtask

  task automatic run_mono(input int n);
    for (int i = 0; i < 5; i++) begin
      mono[i] = 1'b1;
      prev[i] = out[i];
    end
    repeat (n) begin
      tick(1);
      for (int i = 0; i < 5; i++) begin
        if (out[i] > prev[i]) mono[i] = 1'b0;
        prev[i] = out[i];
      end
    end
  endtask

  initial begin
    tick(2);
    chk_all("reset", '0);
    rst = 1'b0;
    in_v = X;
    tick(1);
    chk("step_n0_c1", out[0], X);
    chk("step_n1_c1", out[1], '0);
    tick(1);
    chk("step_n1_c2", out[1], FIRST1);
    chk("step_n2_c2", out[2], '0);
    tick(1);
    chk("step_n2_c3", out[2], SECOND2);
    chk("step_n3_c3", out[3], '0);
    tick(1997);
    chk_all("conv_x", X);
    in_v = XL;
    run_mono(1000);
    for (int i = 0; i < 5; i++) chk($sformatf("mono_down_n%0d", i), D'(mono[i]), D'(1));
    chk_all("conv_low", XL);
    in_v = XH;
    tick(1000);
    chk_all("conv_high", XH);
    in_v = '0;
    tick(20);
    for (int i = 0; i < 5; i++) held[i] = out[i];
    ce = 1'b0;
    repeat (50) begin
      in_v = D'($urandom);
      tick(1);
    end
    for (int i = 0; i < 5; i++) chk($sformatf("hold_n%0d", i), out[i], held[i]);
    in_v = XL;
    ce = 1'b1;
    tick(1);
    chk("resume_n0", out[0], XL);
    chk("resume_n1_decay", D'(out[1] < held[1]), D'(1));
    in_v = X;
    tick(10);
    rst = 1'b1;
    tick(1);
    chk_all("midreset", '0);
    rst = 1'b0;
    tick(1);
    chk("restart_n0", out[0], X);
    chk("restart_n1_c1", out[1], '0);
    tick(1);
    chk("restart_n1_c2", out[1], FIRST1);
    in_v = XM;
    tick(3000);
    chk_all("full_scale", XM);
    in_v = '0;
    run_mono(3000);
    for (int i = 0; i < 5; i++) chk($sformatf("mono_decay_n%0d", i), D'(mono[i]), D'(1));
    chk_all("decay_zero", '0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
